// File: rtl/matrix_engine_pkg.sv
// Shared definitions for the matrix engine bus: module selects, address field layout, default widths.
package matrix_engine_pkg;

  localparam logic [3:0] instructionEnable = 4'h0;
  localparam logic [3:0] memoryEnable      = 4'h1;
  localparam logic [3:0] ALUEnable         = 4'h2;
  localparam logic [3:0] EXEEnable         = 4'h3;
  localparam logic [3:0] registerEnable    = 4'h4;

  // addressBus layout: [15:12] module select, [7:4] lane, [3:0] row
  localparam int unsigned FIELD_W     = 4;
  localparam int unsigned MOD_SEL_LSB = 12;
  localparam int unsigned LANE_LSB    = 4;
  localparam int unsigned ROW_LSB     = 0;

  localparam int unsigned DEFAULT_DATA_WIDTH = 256;
  localparam int unsigned DEFAULT_ELEM_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/reg_clear_sweeper.sv
// Clear-all sequencer: walks row indices 0..DEPTH-1, one per cycle, while busy is high.
module reg_clear_sweeper
  import matrix_engine_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clearAll,
  output logic               busy,
  output logic               clrEn,
  output logic [FIELD_W-1:0] clrIdx
);

  sweep_state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      clrIdx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clearAll) begin
            state  <= SWEEP;
            busy   <= 1'b1;
            clrIdx <= '0;
          end
        end
        SWEEP: begin
          // clearAll is ignored here; the sweep always runs to completion
          if (clrIdx == FIELD_W'(DEPTH - 1)) begin
            state  <= IDLE;
            busy   <= 1'b0;
            clrIdx <= '0;
          end else begin
            clrIdx <= clrIdx + FIELD_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          clrIdx <= '0;
        end
      endcase
    end
  end

  assign clrEn = busy;

endmodule

// File: rtl/matrix_register_file.sv
// DEPTH x DATA_WIDTH register file on the shared matrix-engine bus, with row/element writes,
// one-cycle registered reads onto a tristate output bus, and a clear-all sweep.
module matrix_register_file
  import matrix_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ELEM_WIDTH = DEFAULT_ELEM_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter logic [3:0]  MODULE_ID  = registerEnable
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           addressBus,
  input  logic [DATA_WIDTH-1:0] inputDataBus,
  inout  wire  [DATA_WIDTH-1:0] outputDataBus,
  input  logic                  writeToReg,
  input  logic                  readFromReg,
  input  logic                  elemMode,
  input  logic                  clearAll,
  output logic                  readValid,
  output logic                  busy
);

  localparam int unsigned LANES = DATA_WIDTH / ELEM_WIDTH;

  logic [DATA_WIDTH-1:0] rows [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rd_row_c;
  logic [FIELD_W-1:0]    mod_sel_c;
  logic [FIELD_W-1:0]    lane_idx_c;
  logic [FIELD_W-1:0]    row_idx_c;
  logic                  hit_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  clr_en;
  logic [FIELD_W-1:0]    clr_idx;
  logic                  unused_addr;

  assign mod_sel_c   = addressBus[MOD_SEL_LSB +: FIELD_W];
  assign lane_idx_c  = addressBus[LANE_LSB +: FIELD_W];
  assign row_idx_c   = addressBus[ROW_LSB +: FIELD_W];
  assign unused_addr = ^addressBus[11:8];

  // A pending or starting clear blocks every bus command
  assign hit_c = (mod_sel_c == MODULE_ID) && !busy && !clearAll && (32'(row_idx_c) < DEPTH);
  assign wr_c  = hit_c && writeToReg;
  assign rd_c  = hit_c && readFromReg;

  reg_clear_sweeper #(
    .DEPTH(DEPTH)
  ) u_sweeper (
    .clk     (clk),
    .reset   (reset),
    .clearAll(clearAll),
    .busy    (busy),
    .clrEn   (clr_en),
    .clrIdx  (clr_idx)
  );

  // Read mux on the pre-write contents gives read-before-write for free
  always_comb begin
    rd_row_c = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (row_idx_c == FIELD_W'(r)) rd_row_c = rows[r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) rows[r] <= '0;
      rd_data   <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= rd_c;
      if (rd_c) rd_data <= rd_row_c;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (clr_en && (clr_idx == FIELD_W'(r))) begin
          rows[r] <= '0;
        end else if (wr_c && (row_idx_c == FIELD_W'(r))) begin
          if (elemMode) begin
            for (int unsigned l = 0; l < LANES; l++) begin
              if (lane_idx_c == FIELD_W'(l))
                rows[r][l*ELEM_WIDTH +: ELEM_WIDTH] <= inputDataBus[ELEM_WIDTH-1:0];
            end
          end else begin
            rows[r] <= inputDataBus;
          end
        end
      end
    end
  end

  assign outputDataBus = readValid ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_matrix_register_file.sv
// Directed bench for matrix_register_file (DEPTH=8) with a behavioural reference model.
module tb_matrix_register_file;

  localparam int DW    = 256;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic [15:0]   addressBus;
  logic [DW-1:0] inputDataBus;
  wire  [DW-1:0] outputDataBus;
  logic          writeToReg;
  logic          readFromReg;
  logic          elemMode;
  logic          clearAll;
  logic          readValid;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  matrix_register_file #(
    .DATA_WIDTH(DW),
    .ELEM_WIDTH(16),
    .DEPTH     (DEPTH),
    .MODULE_ID (4'h4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addressBus   (addressBus),
    .inputDataBus (inputDataBus),
    .outputDataBus(outputDataBus),
    .writeToReg   (writeToReg),
    .readFromReg  (readFromReg),
    .elemMode     (elemMode),
    .clearAll     (clearAll),
    .readValid    (readValid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents, pending read result and remaining sweep cycles
  logic [DW-1:0] m_rows [DEPTH];
  logic          m_rv;
  logic [DW-1:0] m_data;
  int            m_sweep_left;
  int            m_idx;
  int            m_lane;
  bit            m_acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) m_rows[r] = '0;
      m_rv = 1'b0;
      m_data = '0;
      m_sweep_left = 0;
    end else begin
      m_idx  = int'(addressBus[3:0]);
      m_lane = int'(addressBus[7:4]);
      m_acc  = (addressBus[15:12] == 4'h4) && (m_sweep_left == 0) && !clearAll && (m_idx < DEPTH);
      m_rv   = m_acc && readFromReg;
      if (m_rv) m_data = m_rows[m_idx];
      if (m_sweep_left > 0) begin
        m_rows[DEPTH - m_sweep_left] = '0;
        m_sweep_left = m_sweep_left - 1;
      end else if (clearAll) begin
        m_sweep_left = DEPTH;
      end
      if (m_acc && writeToReg) begin
        if (elemMode) m_rows[m_idx][m_lane*16 +: 16] = inputDataBus[15:0];
        else m_rows[m_idx] = inputDataBus;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("model_readValid", DW'(readValid), DW'(m_rv));
      chk("model_busy", DW'(busy), DW'(m_sweep_left > 0));
      if (m_rv && readValid) chk("model_data", outputDataBus, m_data);
    end
  end

  task automatic op(input logic [15:0] a, input logic [DW-1:0] d,
                    input logic w, input logic r, input logic e, input logic c);
    addressBus   = a;
    inputDataBus = d;
    writeToReg   = w;
    readFromReg  = r;
    elemMode     = e;
    clearAll     = c;
    @(negedge clk);
  endtask

  task automatic idle();
    op(16'h0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [DW-1:0] pat_d, pat_a, pat_b, pat_e, ones;
  int busy_cycles;

  initial begin
    pat_d = {8{32'hDEADBEEF}};
    pat_a = {16{16'hA5A5}};
    pat_b = {16{16'h5A5A}};
    ones  = '1;
    pat_e = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_1234FFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    reset = 1'b0;
    addressBus = '0; inputDataBus = '0; writeToReg = 0; readFromReg = 0; elemMode = 0; clearAll = 0;
    repeat (3) @(negedge clk);
    chk("reset_readValid", DW'(readValid), '0);
    chk("reset_busy", DW'(busy), '0);
    reset = 1'b1;
    idle();

    // Read of a reset row
    chk("pre_read_idle", DW'(readValid), '0);
    op(16'h4003, '0, 0, 1, 0, 0);
    chk("rst_row3_valid", DW'(readValid), DW'(1));
    chk("rst_row3_data", outputDataBus, '0);
    idle();
    chk("post_read_idle", DW'(readValid), '0);

    // Row write then read next cycle
    op(16'h4005, pat_d, 1, 0, 0, 0);
    op(16'h4005, '0, 0, 1, 0, 0);
    chk("row5_data", outputDataBus, pat_d);

    // Element write into lane 7
    op(16'h4002, ones, 1, 0, 0, 0);
    op(16'h4072, DW'(16'h1234), 1, 0, 1, 0);
    op(16'h4002, '0, 0, 1, 0, 0);
    chk("elem_lane7", outputDataBus, pat_e);

    // Read-before-write on the same row
    op(16'h4001, pat_a, 1, 0, 0, 0);
    op(16'h4001, pat_b, 1, 1, 0, 0);
    chk("rbw_old", outputDataBus, pat_a);
    op(16'h4001, '0, 0, 1, 0, 0);
    chk("rbw_new", outputDataBus, pat_b);

    // Foreign module ID and out-of-range row
    op(16'h1005, pat_a, 1, 0, 0, 0);
    op(16'h400F, pat_a, 1, 0, 0, 0);
    op(16'h400F, '0, 0, 1, 0, 0);
    chk("oor_no_valid", DW'(readValid), '0);
    op(16'h4005, '0, 0, 1, 0, 0);
    chk("foreign_id_row5", outputDataBus, pat_d);

    // Back-to-back reads
    op(16'h4002, '0, 0, 1, 0, 0);
    chk("b2b_valid", DW'(readValid), DW'(1));
    chk("b2b_data", outputDataBus, pat_e);
    idle();

    // Fill, clear while writing, restart attempt mid-sweep
    for (int r = 0; r < DEPTH; r++) op(16'h4000 | 16'(r), {16{16'(r) + 16'h0100}}, 1, 0, 0, 0);
    op(16'h4006, '0, 0, 1, 0, 0);
    chk("fill_row6", outputDataBus, {16{16'h0106}});
    op(16'h0000, '0, 0, 0, 0, 1);
    chk("clear_busy_rise", DW'(busy), DW'(1));
    busy_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      op(16'h4003, ones, 1, 0, 0, (i == 3));
      if (busy) busy_cycles++;
      else break;
    end
    chk("clear_busy_len", DW'(busy_cycles), DW'(DEPTH));
    for (int r = 0; r < DEPTH; r++) begin
      op(16'h4000 | 16'(r), '0, 0, 1, 0, 0);
      chk("cleared_row", outputDataBus, '0);
    end

    // Reset in the middle of a sweep
    for (int r = 0; r < DEPTH; r++) op(16'h4000 | 16'(r), ones, 1, 0, 0, 0);
    op(16'h0000, '0, 0, 0, 0, 1);
    idle();
    idle();
    #2 reset = 1'b0;
    #1 chk("midsweep_busy", DW'(busy), '0);
    chk("midsweep_valid", DW'(readValid), '0);
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      op(16'h4000 | 16'(r), '0, 0, 1, 0, 0);
      chk("post_reset_row", outputDataBus, '0);
    end
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_register_file.md
# matrix_register_file

Parametrised multi-entry register file for the matrix engine, the successor to the single 256-bit bus register. It holds DEPTH rows of DATA_WIDTH bits, decodes the shared 16-bit address bus against its module ID, and supports full-row and single-element writes. It provides a registered, one-cycle-pulsed bus read and a multi-cycle clear-all sweep. It sits on the shared input/output data buses alongside the instruction, memory, ALU and EXE modules.

## Interface
- DATA_WIDTH, 256, row width in bits
- ELEM_WIDTH, 16, element width; DATA_WIDTH must be a multiple; LANES = DATA_WIDTH/ELEM_WIDTH ≤ 16
- DEPTH, 16, number of rows (≤ 16)
- MODULE_ID, 4'h4, value of addressBus[15:12] that selects this block
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- addressBus  input  16  [15:12] module select, [7:4] lane index (element mode), [3:0] row index
- inputDataBus  input  DATA_WIDTH  write data
- outputDataBus  inout  DATA_WIDTH  read data; driven only while readValid=1, else high-Z
- writeToReg  input  1  write request
- readFromReg  input  1  read request
- elemMode  input  1  1: write only lane addressBus[7:4] with inputDataBus[ELEM_WIDTH-1:0]
- clearAll  input  1  start clear sweep (level-sampled)
- readValid  output  1  data on outputDataBus this cycle
- busy  output  1  clear sweep in progress

## Operation
- A request is accepted when addressBus[15:12]==MODULE_ID, busy=0, clearAll=0 and the row index is < DEPTH. Out-of-range rows: writes dropped, reads produce no readValid.
- Row write: row[idx] <= inputDataBus.
- Element write: only lane L=addressBus[7:4] changes; L ≥ LANES is dropped; other lanes are unchanged.
- Read: the row is captured into an output register; readValid=1 for exactly the next cycle, driving outputDataBus; the bus returns to high-Z afterwards.
- Read and write in the same cycle, same row: the read returns the pre-write value (read-before-write). Different rows: both take effect.
- Back-to-back reads: readValid stays high and the data updates each cycle.
- Clear sweep FSM with states IDLE and SWEEP.
  - IDLE→SWEEP when clearAll=1.
  - In SWEEP, row[cnt] <= 0 and cnt increments from 0; SWEEP→IDLE after cnt==DEPTH-1.
  - busy=1 exactly while in SWEEP.
  - clearAll takes priority over a simultaneous read/write, which is dropped.
  - clearAll during SWEEP is ignored; it does not restart the sweep.
  - A read accepted the cycle before clearAll still completes its readValid pulse.

## Timing
- Reset (async assert): all rows 0, readValid=0, busy=0, FSM=IDLE, cnt=0, outputDataBus=Z. Reset mid-sweep aborts the sweep cleanly.
- Write latency: a row is visible to a read issued in the following cycle.
- Read latency: 1 cycle from accepted request to readValid/data.
- Clear: busy rises 1 cycle after clearAll is sampled and lasts DEPTH cycles. The first accepted command is in the cycle after busy falls.
- Commands presented while busy=1 are dropped, not queued.

## Structure
- Shared package matrix_engine_pkg holds:
  - module-enable constants: instructionEnable=4'h0, memoryEnable=4'h1, ALUEnable=4'h2, EXEEnable=4'h3, registerEnable=4'h4
  - address-field bit positions
  - default DATA_WIDTH/ELEM_WIDTH
- One sub-module, reg_clear_sweeper: the FSM plus cnt, outputting busy, clrEn and clrIdx.

## Test plan
- Reset, then read row 3 → readValid pulses 1 cycle with data 0; outputDataBus is Z before and after the pulse.
- Write 256'hDEAD…BEEF to row 5 (addr 16'h4005), read next cycle → same value, latency 1.
- Row 2 = all-ones; element write lane 7 (addr 16'h4072, elemMode=1, data 16'h1234) → row 2 is all-ones except bits [127:112]=16'h1234.
- Write row 1 = A, then the same cycle read row 1 with write B → read returns A; next read returns B.
- Address 16'h1005 write → row 5 unchanged; row index 15 with DEPTH=8 → no write, no readValid.
- Fill all rows, assert clearAll, issue a write during busy → busy high for DEPTH cycles, write dropped, all rows read 0. Repeat with reset asserted mid-sweep → busy=0 immediately and all rows 0.
